// File: rtl/tile_sequencer_if.sv
// tile_seq_if: command, unified-buffer and array signal bundle for tile_sequencer.
// Also holds the precision type; perf_cycles exists only when TILE_SEQ_PERF_EN is defined.
package tile_seq_pkg;
    typedef logic [1:0] precision_mode_t;
endpackage

interface tile_seq_if #(parameter int ADDR_WIDTH = 8, parameter int K_WIDTH = 8);
    import tile_seq_pkg::*;
    logic                  start, abort;
    logic [K_WIDTH-1:0]    k_len;
    logic [ADDR_WIDTH-1:0] a_base, b_base, out_base;
    precision_mode_t       prec_in;
    logic                  busy, done, ub_rd_en;
    logic [ADDR_WIDTH-1:0] ub_a_addr, ub_b_addr, drain_wr_addr;
    logic                  compute_enable, input_first, input_last, weight_first, weight_last;
    logic                  acc_clear, drain_enable, drain_wr_en;
    precision_mode_t       precision_mode;
`ifdef TILE_SEQ_PERF_EN
    logic [31:0]           perf_cycles;
    modport master (output start, abort, k_len, a_base, b_base, out_base, prec_in,
                    input busy, done, ub_rd_en, ub_a_addr, ub_b_addr, compute_enable, input_first,
                    input_last, weight_first, weight_last, acc_clear, drain_enable, drain_wr_en,
                    drain_wr_addr, precision_mode, perf_cycles);
    modport slave  (input start, abort, k_len, a_base, b_base, out_base, prec_in,
                    output busy, done, ub_rd_en, ub_a_addr, ub_b_addr, compute_enable, input_first,
                    output input_last, weight_first, weight_last, acc_clear, drain_enable, drain_wr_en,
                    output drain_wr_addr, precision_mode, perf_cycles);
`else
    modport master (output start, abort, k_len, a_base, b_base, out_base, prec_in,
                    input busy, done, ub_rd_en, ub_a_addr, ub_b_addr, compute_enable, input_first,
                    input_last, weight_first, weight_last, acc_clear, drain_enable, drain_wr_en,
                    drain_wr_addr, precision_mode);
    modport slave  (input start, abort, k_len, a_base, b_base, out_base, prec_in,
                    output busy, done, ub_rd_en, ub_a_addr, ub_b_addr, compute_enable, input_first,
                    output input_last, weight_first, weight_last, acc_clear, drain_enable, drain_wr_en,
                    output drain_wr_addr, precision_mode);
`endif
endinterface

// File: rtl/tile_sequencer.sv
// tile_sequencer: per-tile control FSM (clear, feed, flush, drain, done) for the NxN systolic array.
// Define TILE_SEQ_PERF_EN to add perf_cycles (start-accept to done cycle count, saturating).
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
module tile_sequencer import tile_seq_pkg::*; #(
    parameter int N          = `ARRAY_SIZE,
    parameter int ADDR_WIDTH = 8,
    parameter int K_WIDTH    = 8
) (
    input logic        clk,
    input logic        rst_n,
    tile_seq_if.slave  bus
);
    localparam int NW = $clog2(2 * N);
    localparam int CW = (NW > K_WIDTH) ? NW : K_WIDTH;
    localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * N - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE} state_t;
    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt, w_k_last;
    logic [K_WIDTH-1:0]    r_k;
    logic [ADDR_WIDTH-1:0] r_a, r_b, r_out;
    precision_mode_t       r_prec;
    logic                  r_ce, r_first, r_last;
    logic                  w_accept, w_rd, w_first, w_last, w_drain, w_busy, w_done;
    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_rd     = r_state == S_FEED;
    assign w_drain  = r_state == S_DRAIN;
    assign w_busy   = r_state != S_IDLE;
    assign w_done   = (r_state == S_DONE) && !bus.abort;
    assign w_k_last = CW'(r_k) - CW'(1);
    assign w_first  = w_rd && (r_cnt == '0);
    assign w_last   = w_rd && (r_cnt == w_k_last);
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = bus.start ? ((bus.k_len == '0) ? S_DONE : S_CLEAR) : S_IDLE;
            S_CLEAR: w_next = S_FEED;
            S_FEED:  w_next = (r_cnt == w_k_last) ? S_FLUSH : S_FEED;
            S_FLUSH: w_next = (r_cnt == FLUSH_LAST) ? S_DRAIN : S_FLUSH;
            S_DRAIN: w_next = (r_cnt == DRAIN_LAST) ? S_DONE : S_DRAIN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.abort) w_next = S_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_out   <= '0;
            r_prec  <= '0;
            r_ce    <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || w_next == S_IDLE) ? '0 : r_cnt + CW'(1);
            if (w_accept) begin
                r_k    <= bus.k_len;
                r_a    <= bus.a_base;
                r_b    <= bus.b_base;
                r_out  <= bus.out_base;
                r_prec <= bus.prec_in;
            end else if (w_rd) begin
                r_a <= r_a + ADDR_WIDTH'(1);
                r_b <= r_b + ADDR_WIDTH'(1);
            end
            // an abort also kills the compute pulse that would trail the last read
            r_ce    <= w_rd && !bus.abort;
            r_first <= w_first && !bus.abort;
            r_last  <= w_last && !bus.abort;
        end
    end
    assign bus.busy           = w_busy;
    assign bus.done           = w_done;
    assign bus.acc_clear      = r_state == S_CLEAR;
    assign bus.ub_rd_en       = w_rd;
    assign bus.ub_a_addr      = w_rd ? r_a : '0;
    assign bus.ub_b_addr      = w_rd ? r_b : '0;
    assign bus.compute_enable = r_ce;
    assign bus.input_first    = r_first;
    assign bus.input_last     = r_last;
    assign bus.weight_first   = r_first;
    assign bus.weight_last    = r_last;
    assign bus.drain_enable   = w_drain;
    assign bus.drain_wr_en    = w_drain;
    // bottom row leaves the array first, so addresses count down from out_base+N-1
    assign bus.drain_wr_addr  = w_drain ? r_out + ADDR_WIDTH'(N - 1) - ADDR_WIDTH'(r_cnt) : '0;
    assign bus.precision_mode = r_prec;
`ifdef TILE_SEQ_PERF_EN
    logic [31:0] r_run, r_perf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= '0;
            r_perf <= '0;
        end else begin
            if (w_accept) r_run <= 32'd1;
            else if (w_busy && r_run != '1) r_run <= r_run + 32'd1;
            if (w_done) r_perf <= r_run;
        end
    end
    assign bus.perf_cycles = r_perf;
`endif
endmodule
